sr_latch_driver: RTL
====================

// Module: sr_latch_driver
// PURPOSE
//   Digital sequencer upstream of the analog sr_latch on the ua pins.
//   - Takes set/reset/read commands over a valid/ready handshake.
//   - Drives S and R with timed, mutually exclusive pulses.
//   - Waits for the latch to settle, then samples synchronised Q/QB.
//   - Returns a checked response and keeps saturating pass/fail counters.
//   - Guarantees S and R are never high in the same cycle (forbidden latch input).
// PARAMETERS
//   PULSE_CYCLES   4   S/R high time in clk cycles; legal range >= 1
//   SETTLE_CYCLES  8   idle time after the pulse before sampling; legal range >= 3 (covers sync2)
//   CNT_W          8   width of pass/fail counters
// PORTS
//   clk        in   1      single clock; all logic on rising edge
//   rst        in   1      synchronous, active-high reset
//   cmd_valid  in   1      command present
//   cmd_ready  out  1      block can accept a command (high only in IDLE)
//   cmd_op     in   2      00 READ, 01 SET, 10 RESET, 11 ILLEGAL
//   s_out      out  1      drive to latch S (ua[3] side)
//   r_out      out  1      drive to latch R (ua[0] side)
//   q_in       in   1      latch Q, asynchronous to clk
//   qb_in      in   1      latch QB, asynchronous to clk
//   rsp_valid  out  1      one-cycle response strobe
//   rsp_q      out  1      sampled synchronised Q
//   rsp_err    out  1      response failed its check
//   pass_cnt   out  CNT_W  responses with rsp_err=0; saturates at all-ones
//   fail_cnt   out  CNT_W  responses with rsp_err=1; saturates at all-ones
// BEHAVIOUR
//   - Reset (rst=1 at an edge): next state is IDLE. Every output goes to 0 except cmd_ready=1.
//     Counters and synchroniser flops clear.
//   - Reset mid-operation: s_out/r_out drop at the same edge. Any pending response is discarded.
//   - FSM states: IDLE -> PULSE -> SETTLE -> RESP -> IDLE.
//   - Handshake: a command is accepted at an edge where cmd_valid & cmd_ready.
//     cmd_op is captured at that edge. cmd_ready is 0 in every other state.
//   - SET/RESET: PULSE for exactly PULSE_CYCLES cycles, starting the cycle after acceptance.
//     s_out (SET) or r_out (RESET) is registered high for the whole PULSE; the other stays 0.
//   - READ: skips PULSE and goes straight to SETTLE.
//   - ILLEGAL: skips PULSE and SETTLE; goes directly to RESP with rsp_err=1.
//   - SETTLE: s_out = r_out = 0 for SETTLE_CYCLES cycles.
//     The q_s/qb_s samples (2-flop synchronised) taken on the last SETTLE cycle feed RESP.
//   - RESP: rsp_valid=1 for exactly one cycle with rsp_q=q_s. Next state is IDLE.
//   - Latency from the accept edge to rsp_valid high:
//     SET/RESET = PULSE_CYCLES+SETTLE_CYCLES+1 cycles; READ = SETTLE_CYCLES+1; ILLEGAL = 1.
//   - rsp_err=1 if any of:
//     - q_s == qb_s (invalid or metastable pair);
//     - op SET and q_s=0;
//     - op RESET and q_s=1;
//     - op ILLEGAL.
//     READ checks only q_s != qb_s.
//   - Counters: on the rsp_valid cycle, exactly one of pass_cnt/fail_cnt increments.
//     A counter at all-ones holds.
//   - Invariant: s_out & r_out is never 1, including across reset and back-to-back commands.
//   - Back-to-back: a new command is accepted no earlier than the IDLE cycle after RESP.
//   - rsp_q, rsp_err hold their last values while rsp_valid=0.
// STRUCTURE
//   - Package sr_drv_pkg holds: the op_t enum (READ/SET/RESET/ILLEGAL), the state_t enum
//     (IDLE/PULSE/SETTLE/RESP), and OP_W=2.
//   - Sub-module sync2: two-flop synchroniser with synchronous active-high reset to 0.
//     Instantiate it twice, for q_in and qb_in.
//   - One down-counter is shared by PULSE and SETTLE, sized for the larger parameter.
// TESTING
//   1. Reset then idle: rst high 2 cycles -> cmd_ready=1, s_out=r_out=0, rsp_valid=0, counters=0.
//   2. SET with model latch (Q follows S after 2 cycles):
//      -> s_out high cycles 1..4 after accept; rsp_valid at cycle 13 with rsp_q=1, rsp_err=0;
//         pass_cnt=1.
//   3. RESET then READ back-to-back:
//      -> r_out pulse of 4 cycles; READ response at accept+9 with rsp_q=0, rsp_err=0;
//         cmd_ready=0 throughout each operation.
//   4. ILLEGAL op 11 -> no S/R activity; rsp_valid the cycle after accept with rsp_err=1;
//      fail_cnt=1.
//   5. Faulty latch (q_in=qb_in=1 forced) + SET -> rsp_err=1.
//      Run 260 such commands with CNT_W=8 -> fail_cnt saturates at 255.
//   6. Assert rst during the PULSE cycle 2 of a SET -> s_out=0 after that edge, no rsp_valid,
//      FSM in IDLE; assertion s_out&r_out never 1 over a randomised 10k-command run.

Source files
------------

// File: rtl/sr_latch_driver_pkg.sv
// Shared types for the sr_latch sequencer.
//   op_t    : command opcode carried on cmd_op
//   state_t : sequencer FSM states
//   OP_W    : opcode width
//   rsp_check() : pass/fail rule applied to a synchronised Q/QB sample
package sr_drv_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_READ    = 2'b00,
        OP_SET     = 2'b01,
        OP_RESET   = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_SETTLE,
        ST_RESP
    } state_t;

    // A complementary Q/QB pair is required for every op; SET and RESET
    // additionally require Q to reflect the pulse that was just driven.
    function automatic logic rsp_check(op_t op, logic q, logic qb);
        return (q == qb)
            || (op == OP_SET     && !q)
            || (op == OP_RESET   &&  q)
            || (op == OP_ILLEGAL);
    endfunction

endpackage

// File: rtl/sr_latch_driver_if.sv
// Command/response bus between a host and sr_latch_driver.
//   cmd_valid/cmd_ready/cmd_op : command handshake (host -> driver)
//   rsp_valid/rsp_q/rsp_err    : one-cycle response strobe (driver -> host)
// Modports: master = host side, slave = driver side.
interface sr_latch_driver_if;
    import sr_drv_pkg::*;

    logic cmd_valid;
    logic cmd_ready;
    op_t  cmd_op;
    logic rsp_valid;
    logic rsp_q;
    logic rsp_err;

    modport master (
        output cmd_valid, cmd_op,
        input  cmd_ready, rsp_valid, rsp_q, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op,
        output cmd_ready, rsp_valid, rsp_q, rsp_err
    );

endinterface

// File: rtl/sr_latch_driver_sync2.sv
// Two-flop synchroniser for a single asynchronous input.
//   clk : sampling clock
//   rst : synchronous active-high reset, clears both flops to 0
//   d   : asynchronous input
//   q   : synchronised output, two clk edges behind d
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sr_latch_driver.sv
// Sequencer for the analog SR latch: accepts READ/SET/RESET commands,
// drives mutually exclusive timed S/R pulses, waits for the latch to settle,
// samples synchronised Q/QB and returns a checked response, keeping
// saturating pass/fail counters.
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : command handshake and response strobe
//   s_out, r_out      : latch S / R drives, never high together
//   q_in, qb_in       : latch outputs, asynchronous to clk
//   pass_cnt/fail_cnt : saturating response counters
module sr_latch_driver
    import sr_drv_pkg::*;
#(
    parameter int PULSE_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst,
    sr_latch_driver_if.slave   bus,
    output logic               s_out,
    output logic               r_out,
    input  logic               q_in,
    input  logic               qb_in,
    output logic [CNT_W-1:0]   pass_cnt,
    output logic [CNT_W-1:0]   fail_cnt
);

    // One down-counter serves both timed phases; it counts N-1 .. 0.
    localparam int MAXC = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
    localparam int CW   = (MAXC > 2) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] PULSE_LD  = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);

    state_t          state, state_nxt;
    op_t             op_q, op_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            s_nxt, r_nxt;
    logic            rsp_valid, rsp_q, rsp_err;
    logic            rv_nxt, rq_nxt, re_nxt;
    logic            q_s, qb_s;

    sync2 u_sync_q  (.clk(clk), .rst(rst), .d(q_in),  .q(q_s));
    sync2 u_sync_qb (.clk(clk), .rst(rst), .d(qb_in), .q(qb_s));

    assign bus.cmd_ready = (state == ST_IDLE);
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_q     = rsp_q;
    assign bus.rsp_err   = rsp_err;

    always_comb begin
        state_nxt = state;
        op_nxt    = op_q;
        cnt_nxt   = cnt;
        s_nxt     = s_out;
        r_nxt     = r_out;
        rv_nxt    = 1'b0;
        rq_nxt    = rsp_q;
        re_nxt    = rsp_err;
        unique case (state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    op_nxt = bus.cmd_op;
                    unique case (bus.cmd_op)
                        OP_SET: begin
                            state_nxt = ST_PULSE;
                            cnt_nxt   = PULSE_LD;
                            s_nxt     = 1'b1;
                        end
                        OP_RESET: begin
                            state_nxt = ST_PULSE;
                            cnt_nxt   = PULSE_LD;
                            r_nxt     = 1'b1;
                        end
                        OP_READ: begin
                            state_nxt = ST_SETTLE;
                            cnt_nxt   = SETTLE_LD;
                        end
                        default: begin
                            // Illegal op: answer immediately, no latch activity.
                            state_nxt = ST_RESP;
                            rv_nxt    = 1'b1;
                            rq_nxt    = q_s;
                            re_nxt    = 1'b1;
                        end
                    endcase
                end
            end
            ST_PULSE: begin
                if (cnt == '0) begin
                    state_nxt = ST_SETTLE;
                    cnt_nxt   = SETTLE_LD;
                    s_nxt     = 1'b0;
                    r_nxt     = 1'b0;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            ST_SETTLE: begin
                // The sample on the last settle cycle becomes the response.
                if (cnt == '0) begin
                    state_nxt = ST_RESP;
                    rv_nxt    = 1'b1;
                    rq_nxt    = q_s;
                    re_nxt    = rsp_check(op_q, q_s, qb_s);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                s_nxt     = 1'b0;
                r_nxt     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            op_q      <= OP_READ;
            cnt       <= '0;
            s_out     <= 1'b0;
            r_out     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_q     <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            op_q      <= op_nxt;
            cnt       <= cnt_nxt;
            s_out     <= s_nxt;
            r_out     <= r_nxt;
            rsp_valid <= rv_nxt;
            rsp_q     <= rq_nxt;
            rsp_err   <= re_nxt;
        end
    end

    // Counters advance on the edge that closes the response cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else if (rsp_valid) begin
            if (rsp_err) begin
                if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
            end else begin
                if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
            end
        end
    end

endmodule
